// File: rtl/atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// atm_txn_ctrl
// Transaction sequencer that drives the 16-entry account RegFile. It takes one
// ATM request (balance / deposit / withdraw), does a read-modify-write of the
// selected account, and returns the status and resulting balance. Only one
// transaction is in flight at a time.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_op/acct/amount       00 BALANCE, 01 DEPOSIT, 10 WITHDRAW, 11 reserved
//   resp_valid/resp_ready    response handshake (valid held until accepted)
//   resp_status/balance      00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_OP
//   rf_we/sel/wdata          RegFile write enable, account select, write data
//   rf_rdata                 RegFile read data (registered, 1-cycle latency)
//   txn_count                completed responses, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module atm_txn_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_acct,
    input  logic [DATA_W-1:0] req_amount,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_status,
    output logic [DATA_W-1:0] resp_balance,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_sel,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [CNT_W-1:0]  txn_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WDR = 2'b10;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_BADOP = 2'b11;

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_amount;
    logic [ADDR_W-1:0] r_sel;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_resp_valid;
    logic [1:0]        r_status;
    logic [DATA_W-1:0] r_balance;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [1:0]        w_status;
    logic [DATA_W-1:0] w_result;
    logic              w_write;

    // Outcome of the transaction, evaluated in CAP when rf_rdata is valid.
    // The extra sum bit is the deposit carry used for overflow detection.
    always_comb begin
        w_sum    = {1'b0, rf_rdata} + {1'b0, r_amount};
        w_diff   = rf_rdata - r_amount;
        w_status = ST_OK;
        w_result = rf_rdata;
        w_write  = 1'b0;
        case (r_op)
            OP_BAL: begin
                w_status = ST_OK;
            end
            OP_DEP: begin
                if (w_sum[DATA_W]) begin
                    w_status = ST_OVF;
                end else begin
                    w_result = w_sum[DATA_W-1:0];
                    w_write  = 1'b1;
                end
            end
            OP_WDR: begin
                if (r_amount > rf_rdata) begin
                    w_status = ST_INSUF;
                end else begin
                    w_result = w_diff;
                    w_write  = 1'b1;
                end
            end
            default: begin
                w_status = ST_BADOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_amount     <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_status     <= '0;
            r_balance    <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_amount <= req_amount;
                        r_sel    <= req_acct;
                        r_state  <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_status  <= w_status;
                    r_balance <= w_result;
                    if (w_write) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_result;
                        r_state <= S_WR;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_WR: begin
                    r_we         <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_count      <= r_count + CNT_W'(1);
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_status  = r_status;
    assign resp_balance = r_balance;
    assign rf_we        = r_we;
    assign rf_sel       = r_sel;
    assign rf_wdata     = r_wdata;
    assign txn_count    = r_count;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
module tb_atm_txn_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_acct;
    logic [DATA_W-1:0] req_amount;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_status;
    logic [DATA_W-1:0] resp_balance;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_sel;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic [CNT_W-1:0]  txn_count;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent transaction
    int                t_lat;
    int                t_we_cnt;
    logic [ADDR_W-1:0] t_we_sel;
    logic [DATA_W-1:0] t_we_data;
    logic [1:0]        t_status;
    logic [DATA_W-1:0] t_bal;

    // RegFile model: registered read, synchronous write
    logic [DATA_W-1:0] mem [16];
    logic              mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rf_rdata <= '0;
        end else begin
            if (rf_we) mem[rf_sel] <= rf_wdata;
            rf_rdata <= mem[rf_sel];
        end
    end

    always #5 clk = ~clk;

    atm_txn_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_acct    (req_acct),
        .req_amount  (req_amount),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_balance(resp_balance),
        .rf_we       (rf_we),
        .rf_sel      (rf_sel),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .txn_count   (txn_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, watch it to completion (bounded), then accept the
    // response after 'hold' cycles of resp_ready=0. Called #1 after a posedge.
    task automatic txn(input logic [1:0] op, input logic [ADDR_W-1:0] acct,
                       input logic [DATA_W-1:0] amt, input int hold);
        t_lat = 0; t_we_cnt = 0; t_we_sel = '0; t_we_data = '0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_acct = acct; req_amount = amt;
        @(posedge clk); #1;
        // Scramble request inputs: they must be ignored once accepted
        req_valid = 1'b0; req_op = 2'b11; req_acct = 4'hF; req_amount = 32'hDEAD_BEEF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rf_we) begin
                t_we_cnt++;
                t_we_sel  = rf_sel;
                t_we_data = rf_wdata;
            end
            if (resp_valid) begin
                t_lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        t_status = resp_status;
        t_bal    = resp_balance;
        if (t_lat == 0) chk("resp_timeout", 64'(resp_valid), 64'd1);
        if (hold > 0) begin
            // A competing request is presented while the response is pending
            req_valid = 1'b1; req_op = 2'b00; req_acct = acct; req_amount = '0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_resp_valid", 64'(resp_valid), 64'd1);
                chk("hold_status", 64'(resp_status), 64'(t_status));
                chk("hold_balance", 64'(resp_balance), 64'(t_bal));
                chk("hold_req_ready", 64'(req_ready), 64'd0);
                chk("hold_rf_we", 64'(rf_we), 64'd0);
            end
            req_valid = 1'b0;
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_op = '0; req_acct = '0; req_amount = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_status", 64'(resp_status), 64'd0);
        chk("rst_balance", 64'(resp_balance), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_sel", 64'(rf_sel), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_txn_count", 64'(txn_count), 64'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        // 1: deposit 100 into acct 3
        txn(2'b01, 4'd3, 32'd100, 0);
        chk("t1_lat", 64'(t_lat), 64'd4);
        chk("t1_we_cnt", 64'(t_we_cnt), 64'd1);
        chk("t1_we_sel", 64'(t_we_sel), 64'd3);
        chk("t1_we_data", 64'(t_we_data), 64'd100);
        chk("t1_status", 64'(t_status), 64'd0);
        chk("t1_bal", 64'(t_bal), 64'd100);
        chk("t1_count", 64'(txn_count), 64'd1);

        // 2: withdraw 150 (insufficient), then withdraw exactly 100
        txn(2'b10, 4'd3, 32'd150, 0);
        chk("t2a_lat", 64'(t_lat), 64'd3);
        chk("t2a_we_cnt", 64'(t_we_cnt), 64'd0);
        chk("t2a_status", 64'(t_status), 64'd1);
        chk("t2a_bal", 64'(t_bal), 64'd100);
        txn(2'b10, 4'd3, 32'd100, 0);
        chk("t2b_lat", 64'(t_lat), 64'd4);
        chk("t2b_we_cnt", 64'(t_we_cnt), 64'd1);
        chk("t2b_we_data", 64'(t_we_data), 64'd0);
        chk("t2b_status", 64'(t_status), 64'd0);
        chk("t2b_bal", 64'(t_bal), 64'd0);
        chk("t2b_count", 64'(txn_count), 64'd3);

        // 3: fill acct 5 to all-ones, overflow deposit, balance unchanged
        txn(2'b01, 4'd5, 32'hFFFF_FFFF, 0);
        chk("t3a_status", 64'(t_status), 64'd0);
        chk("t3a_bal", 64'(t_bal), 64'hFFFF_FFFF);
        txn(2'b01, 4'd5, 32'd1, 0);
        chk("t3b_lat", 64'(t_lat), 64'd3);
        chk("t3b_we_cnt", 64'(t_we_cnt), 64'd0);
        chk("t3b_status", 64'(t_status), 64'd2);
        chk("t3b_bal", 64'(t_bal), 64'hFFFF_FFFF);
        txn(2'b00, 4'd5, 32'd0, 0);
        chk("t3c_status", 64'(t_status), 64'd0);
        chk("t3c_bal", 64'(t_bal), 64'hFFFF_FFFF);
        chk("t3c_count", 64'(txn_count), 64'd6);

        // 4: deposit 100, BALANCE, BAD_OP, amount-0 deposit
        txn(2'b01, 4'd3, 32'd100, 0);
        chk("t4a_bal", 64'(t_bal), 64'd100);
        txn(2'b00, 4'd3, 32'd55, 0);
        chk("t4b_lat", 64'(t_lat), 64'd3);
        chk("t4b_we_cnt", 64'(t_we_cnt), 64'd0);
        chk("t4b_status", 64'(t_status), 64'd0);
        chk("t4b_bal", 64'(t_bal), 64'd100);
        txn(2'b11, 4'd3, 32'd7, 0);
        chk("t4c_lat", 64'(t_lat), 64'd3);
        chk("t4c_we_cnt", 64'(t_we_cnt), 64'd0);
        chk("t4c_status", 64'(t_status), 64'd3);
        chk("t4c_bal", 64'(t_bal), 64'd100);
        txn(2'b01, 4'd3, 32'd0, 0);
        chk("t4d_we_cnt", 64'(t_we_cnt), 64'd1);
        chk("t4d_we_data", 64'(t_we_data), 64'd100);
        chk("t4d_status", 64'(t_status), 64'd0);
        chk("t4d_count", 64'(txn_count), 64'd10);

        // 5: withdraw 40 with resp_ready held low 5 cycles
        txn(2'b10, 4'd3, 32'd40, 5);
        chk("t5a_status", 64'(t_status), 64'd0);
        chk("t5a_bal", 64'(t_bal), 64'd60);
        chk("t5a_count", 64'(txn_count), 64'd11);
        chk("t5_accept_after_hs", 64'(req_ready), 64'd1);
        txn(2'b00, 4'd3, 32'd0, 0);
        chk("t5b_lat", 64'(t_lat), 64'd3);
        chk("t5b_bal", 64'(t_bal), 64'd60);
        chk("t5b_count", 64'(txn_count), 64'd12);

        // 6: reset during CAP of a deposit
        req_valid = 1'b1; req_op = 2'b01; req_acct = 4'd3; req_amount = 32'd50;
        @(posedge clk); #1;           // accept edge, now RD
        req_valid = 1'b0;
        @(posedge clk); #1;           // now CAP
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_req_ready", 64'(req_ready), 64'd1);
        chk("t6_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_status", 64'(resp_status), 64'd0);
        chk("t6_balance", 64'(resp_balance), 64'd0);
        chk("t6_rf_we", 64'(rf_we), 64'd0);
        chk("t6_rf_sel", 64'(rf_sel), 64'd0);
        chk("t6_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("t6_count", 64'(txn_count), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_we", 64'(rf_we), 64'd0);
            @(posedge clk); #1;
        end
        txn(2'b00, 4'd3, 32'd0, 0);
        chk("t6_bal_kept", 64'(t_bal), 64'd60);
        chk("t6_count_after", 64'(txn_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
